// File: rtl/noc_endpoint_tx.sv
// noc_endpoint_tx: endpoint-side flit injector for the ring NoC local port.
// Buffers client flits in a small FIFO, stamps every flit of a packet with the
// head flit's destination, and injects into the router under credit-based flow
// control (one credit per free router buffer slot).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_data/in_dest/in_last    client flit, destination (head only), tail marker
//   in_valid/in_ready          client stream handshake
//   data_out/dest_out/
//   is_tail_out/send_out       registered flit towards the router local input
//   credit_in                  one-cycle pulse per slot freed in the router
//   credit_count               credits currently held
//   credit_overflow            sticky: credit returned while already full
//   idle                       FIFO empty, credits full, no packet open
module noc_endpoint_tx #(
  parameter int unsigned FLIT_WIDTH  = 256,
  parameter int unsigned DEST_WIDTH  = 4,
  parameter int unsigned NUM_CREDITS = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [FLIT_WIDTH-1:0]              in_data,
  input  logic [DEST_WIDTH-1:0]              in_dest,
  input  logic                               in_last,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [FLIT_WIDTH-1:0]              data_out,
  output logic [DEST_WIDTH-1:0]              dest_out,
  output logic                               is_tail_out,
  output logic                               send_out,
  input  logic                               credit_in,
  output logic [$clog2(NUM_CREDITS+1)-1:0]   credit_count,
  output logic                               credit_overflow,
  output logic                               idle
);

  localparam int unsigned CRED_W = $clog2(NUM_CREDITS + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic {ST_HEAD, ST_BODY} state_e;

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  last;
  } entry_t;

  entry_t              mem_q [FIFO_DEPTH];
  state_e              state_q, state_d;
  logic [DEST_WIDTH-1:0] cur_dest_q, cur_dest_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CRED_W-1:0]   credit_q, credit_d;
  logic                overflow_q, overflow_d;
  entry_t              out_q, out_d;
  logic                send_q, send_d;
  logic                push, pop;
  entry_t              wr_entry;

  // Ready and idle derive from registered state only.
  assign in_ready        = (count_q < CNT_W'(FIFO_DEPTH));
  assign idle            = (count_q == '0) && (credit_q == CRED_W'(NUM_CREDITS))
                           && (state_q == ST_HEAD);
  assign data_out        = out_q.data;
  assign dest_out        = out_q.dest;
  assign is_tail_out     = out_q.last;
  assign send_out        = send_q;
  assign credit_count    = credit_q;
  assign credit_overflow = overflow_q;

  // Next-state: packet FSM, FIFO pointers, injection and credit accounting.
  always_comb begin
    state_d    = state_q;
    cur_dest_d = cur_dest_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    credit_d   = credit_q;
    overflow_d = overflow_q;
    out_d      = out_q;
    send_d     = 1'b0;

    push = in_valid && in_ready;
    // Credits sampled from the register: a credit pulse only helps next cycle.
    pop  = (count_q != '0) && (credit_q != '0);

    wr_entry.data = in_data;
    wr_entry.last = in_last;
    wr_entry.dest = (state_q == ST_HEAD) ? in_dest : cur_dest_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (state_q == ST_HEAD) cur_dest_d = in_dest;
      state_d = in_last ? ST_HEAD : ST_BODY;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      out_d    = mem_q[rd_ptr_q];
      send_d   = 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    unique case ({pop, credit_in})
      2'b10: credit_d = credit_q - CRED_W'(1);
      2'b01: begin
        if (credit_q == CRED_W'(NUM_CREDITS)) overflow_d = 1'b1;
        else                                  credit_d   = credit_q + CRED_W'(1);
      end
      default: credit_d = credit_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HEAD;
      cur_dest_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credit_q   <= CRED_W'(NUM_CREDITS);
      overflow_q <= 1'b0;
      out_q      <= '0;
      send_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_dest_q <= cur_dest_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
      out_q      <= out_d;
      send_q     <= send_d;
    end
  end

  // FIFO storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

endmodule

// File: tb/tb_noc_endpoint_tx.sv
// Self-checking bench for noc_endpoint_tx: directed table, hand-written corner
// sequences and a randomized phase, all checked against a queue-based model.
module tb_noc_endpoint_tx;

  localparam int FW = 256;
  localparam int DW = 4;
  localparam int NC = 2;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] in_data;
  logic [DW-1:0] in_dest;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] data_out;
  logic [DW-1:0] dest_out;
  logic          is_tail_out;
  logic          send_out;
  logic          credit_in;
  logic [1:0]    credit_count;
  logic          credit_overflow;
  logic          idle;

  noc_endpoint_tx #(
    .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_CREDITS(NC), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dest(in_dest),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in), .credit_count(credit_count),
    .credit_overflow(credit_overflow), .idle(idle)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: flit queue, credit integer, packet-open flag.
  typedef struct {
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    logic          last;
  } flit_t;

  flit_t         q[$];
  int            m_cred;
  bit            m_ovf;
  bit            m_open;
  logic [DW-1:0] m_pdest;
  logic [FW-1:0] m_data;
  logic [DW-1:0] m_dest;
  logic          m_tail;
  bit            m_send;
  bit            m_acc;

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cred = NC; m_ovf = 0; m_open = 0; m_pdest = '0;
    m_data = '0; m_dest = '0; m_tail = 0; m_send = 0; m_acc = 0;
  endtask

  // One clock of the model, from the inputs present before the edge.
  task automatic model_step();
    bit    pop_m;
    flit_t e;
    pop_m = (q.size() > 0) && (m_cred > 0);
    m_acc = in_valid && (q.size() < FD);
    m_send = 0;
    if (pop_m) begin
      e = q.pop_front();
      m_data = e.data; m_dest = e.dest; m_tail = e.last; m_send = 1;
    end
    if (m_acc) begin
      e.data = in_data;
      e.dest = m_open ? m_pdest : in_dest;
      if (!m_open) m_pdest = in_dest;
      e.last = in_last;
      q.push_back(e);
      m_open = !in_last;
    end
    if (pop_m && !credit_in)      m_cred--;
    else if (!pop_m && credit_in) begin
      if (m_cred == NC) m_ovf = 1;
      else              m_cred++;
    end
  endtask

  task automatic compare_all();
    chk("send_out",        FW'(send_out),        FW'(m_send));
    chk("data_out",        data_out,             m_data);
    chk("dest_out",        FW'(dest_out),        FW'(m_dest));
    chk("is_tail_out",     FW'(is_tail_out),     FW'(m_tail));
    chk("credit_count",    FW'(credit_count),    FW'(m_cred));
    chk("credit_overflow", FW'(credit_overflow), FW'(m_ovf));
    chk("in_ready",        FW'(in_ready),        FW'(q.size() < FD));
    chk("idle",            FW'(idle),            FW'(q.size() == 0 && m_cred == NC && !m_open));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_send"},   FW'(send_out),        '0);
    chk({tag, "_data"},   data_out,             '0);
    chk({tag, "_dest"},   FW'(dest_out),        '0);
    chk({tag, "_tail"},   FW'(is_tail_out),     '0);
    chk({tag, "_ready"},  FW'(in_ready),        FW'(1));
    chk({tag, "_cred"},   FW'(credit_count),    FW'(2));
    chk({tag, "_ovf"},    FW'(credit_overflow), '0);
    chk({tag, "_idle"},   FW'(idle),            FW'(1));
  endtask

  typedef struct {
    logic       v;
    logic       last;
    logic [3:0] dest;
    logic       cr;
    logic       e_send;
    logic [3:0] e_dest;
    logic       e_tail;
    int         e_cred;
  } vec_t;

  vec_t vt[19];

  task automatic set_in(input logic v, input logic l, input logic [3:0] d, input logic c);
    in_valid = v; in_last = l; in_dest = d; credit_in = c;
  endtask

  initial begin
    int sends;
    int k;
    int guard;

    // Starvation (4-flit packet dest 5), simultaneous inject+credit,
    // then dest latching (head dest 3, body dest 9).
    vt[0]  = '{1, 0, 5, 0, 0, 0, 0, 2};
    vt[1]  = '{1, 0, 9, 0, 1, 5, 0, 1};
    vt[2]  = '{1, 0, 9, 0, 1, 5, 0, 0};
    vt[3]  = '{1, 1, 9, 0, 0, 5, 0, 0};
    vt[4]  = '{0, 0, 0, 0, 0, 5, 0, 0};
    vt[5]  = '{0, 0, 0, 1, 0, 5, 0, 1};
    vt[6]  = '{0, 0, 0, 0, 1, 5, 0, 0};
    vt[7]  = '{0, 0, 0, 0, 0, 5, 0, 0};
    vt[8]  = '{0, 0, 0, 1, 0, 5, 0, 1};
    vt[9]  = '{0, 0, 0, 1, 1, 5, 1, 1};
    vt[10] = '{0, 0, 0, 1, 0, 5, 1, 2};
    vt[11] = '{1, 0, 3, 0, 0, 5, 1, 2};
    vt[12] = '{1, 0, 9, 0, 1, 3, 0, 1};
    vt[13] = '{1, 1, 9, 0, 1, 3, 0, 0};
    vt[14] = '{0, 0, 0, 0, 0, 3, 0, 0};
    vt[15] = '{0, 0, 0, 1, 0, 3, 0, 1};
    vt[16] = '{0, 0, 0, 0, 1, 3, 1, 0};
    vt[17] = '{0, 0, 0, 1, 0, 3, 1, 1};
    vt[18] = '{0, 0, 0, 1, 0, 3, 1, 2};

    rst_n = 0; in_data = '0;
    set_in(0, 0, 0, 0);
    model_reset();
    #12;
    check_reset_values("por");
    rst_n = 1;

    for (int i = 0; i < 19; i++) begin
      set_in(vt[i].v, vt[i].last, vt[i].dest, vt[i].cr);
      in_data = FW'(i + 256);
      cycle();
      chk($sformatf("vec%0d_send", i), FW'(send_out),     FW'(vt[i].e_send));
      chk($sformatf("vec%0d_dest", i), FW'(dest_out),     FW'(vt[i].e_dest));
      chk($sformatf("vec%0d_tail", i), FW'(is_tail_out),  FW'(vt[i].e_tail));
      chk($sformatf("vec%0d_cred", i), FW'(credit_count), FW'(vt[i].e_cred));
    end

    // Overflow at full credits while idle; flag must stick.
    set_in(0, 0, 0, 1);
    cycle();
    chk("ovf_set",  FW'(credit_overflow), FW'(1));
    chk("ovf_cred", FW'(credit_count),    FW'(2));
    set_in(0, 0, 0, 0);
    repeat (3) cycle();
    chk("ovf_sticky", FW'(credit_overflow), FW'(1));

    // Reset asserted mid-cycle with a packet open and flits in flight.
    set_in(1, 0, 4'hA, 0);
    in_data = FW'(32'hDEAD_0001);
    cycle();
    in_data = FW'(32'hDEAD_0002);
    cycle();
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_reset_values("rst_async");
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_hold_send", FW'(send_out),     '0);
      chk("rst_hold_cred", FW'(credit_count), FW'(2));
    end
    #3;
    rst_n = 1;
    set_in(0, 0, 0, 0);
    cycle();

    // Full FIFO: spend both credits, then push 6 flits with no credits.
    set_in(1, 0, 1, 0); in_data = FW'(32'hF000_0000); cycle();
    set_in(1, 1, 1, 0); in_data = FW'(32'hF000_0001); cycle();
    set_in(0, 0, 0, 0); cycle(); cycle();
    chk("full_cred0", FW'(credit_count), '0);
    k = 0;
    for (int c = 0; c < 6; c++) begin
      set_in(1, k == 5, 7, 0);
      in_data = FW'(32'hAB00_0000 + k);
      cycle();
      if (m_acc) k++;
      if (k == 4 && c == 3) chk("full_ready_low", FW'(in_ready), '0);
    end
    chk("full_accepted4", FW'(k), FW'(4));
    sends = 0;
    guard = 0;
    while ((k < 6 || q.size() > 0) && guard < 100) begin
      set_in(k < 6, k == 5, 7, (m_cred < NC) && guard[0]);
      in_data = FW'(32'hAB00_0000 + k);
      cycle();
      if (m_acc) k++;
      if (send_out) sends++;
      guard++;
    end
    chk("full_drain_bound", FW'(guard < 100), FW'(1));
    chk("full_sends",       FW'(sends),       FW'(6));

    // Randomized traffic with a well-behaved router returning credits.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 3) == 0);
      in_dest   = DW'($urandom);
      for (int w = 0; w < FW / 32; w++) in_data[w*32 +: 32] = $urandom;
      credit_in = (m_cred < NC) && ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/noc_endpoint_tx.md
# noc_endpoint_tx

Endpoint-side flit injector for the ring NoC's native input port. It accepts flits from a client over a valid/ready stream and buffers them in a small FIFO. It drives `send`/`data`/`dest`/`is_tail` into a router's local input and obeys credit-based flow control: one credit per free router buffer slot, returned as single-cycle `credit` pulses. One instance sits between each client and its router port 0.

## Interface
- `FLIT_WIDTH`, 256: flit payload width.
- `DEST_WIDTH`, 4: destination endpoint id width.
- `NUM_CREDITS`, 2: initial credit count; must equal the router `FLIT_BUFFER_DEPTH`; must be 1 or more.
- `FIFO_DEPTH`, 4: local flit FIFO depth; power of two, 2 or more.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_data` in FLIT_WIDTH: client flit payload.
- `in_dest` in DEST_WIDTH: destination id; sampled on head flits only.
- `in_last` in 1: the flit is the packet tail.
- `in_valid` in 1: a client flit is present.
- `in_ready` out 1: the FIFO can accept a flit.
- `data_out` out FLIT_WIDTH: to the router `data_in`.
- `dest_out` out DEST_WIDTH: to the router `dest_in`.
- `is_tail_out` out 1: to the router `is_tail_in`.
- `send_out` out 1: one-cycle pulse per flit injected.
- `credit_in` in 1: from the router `credit_out`; one-cycle pulse per freed slot.
- `credit_count` out $clog2(NUM_CREDITS+1): current credits.
- `credit_overflow` out 1: sticky error flag.
- `idle` out 1: FIFO empty, credits full, no packet open.

## Operation
- **Accept.** A flit is accepted when `in_valid && in_ready`.
- **`in_ready`.** Equals `fifo_count < FIFO_DEPTH` and depends only on registered count. A full FIFO never accepts, even in a cycle with a simultaneous pop.
- **Packet FSM.** States are HEAD (reset) and BODY.
  - In HEAD, an accepted flit latches `in_dest` into `cur_dest`. That flit is stored with `in_dest`.
  - In BODY, `in_dest` is ignored and the flit is stored with `cur_dest`.
  - An accepted flit with `in_last` goes to HEAD; without `in_last` it goes to BODY.
  - A single-flit packet (head with `in_last`) stays in HEAD.
- **FIFO entry.** Each entry holds {data, dest, last}.
- **Inject.** Inject when the FIFO is non-empty and `credit_count > 0`. Injection pops the FIFO and registers the entry onto `data_out`/`dest_out`/`is_tail_out`, with `send_out`=1 for exactly one cycle.
  - When no injection occurs, `send_out`=0 and the data/dest/tail outputs hold their last value.
- **Credit counter.** Resets to NUM_CREDITS.
  - Decrements on inject and increments on `credit_in`.
  - If both occur in the same cycle, the count is unchanged.
  - `credit_in` with the count already at NUM_CREDITS and no inject in that cycle sets `credit_overflow` and leaves the count saturated.
  - The count never goes below 0; this is guaranteed by the inject condition.
- **No bypass.** A credit pulse in cycle t can enable an injection decided in cycle t+1 at the earliest.
- **`credit_overflow`.** Cleared only by reset.

## Timing
- **Reset values.** `send_out`=0, `data_out`=0, `dest_out`=0, `is_tail_out`=0, `in_ready`=1, `credit_count`=NUM_CREDITS, `credit_overflow`=0, `idle`=1. FSM is in HEAD and the FIFO is empty.
- **Latency.** A flit accepted at edge k is FIFO-visible after k. It can be injected at edge k+1, with `send_out` high during the cycle after edge k+1. This gives a minimum latency of 1 cycle.
- **Throughput.** With credits available, sustained throughput is 1 flit per cycle.
- **Credit-limited rate.** With round-trip credit latency R cycles, steady-state throughput is NUM_CREDITS per R cycles.
- **Ordering.** Flits leave in acceptance order. Packets are never interleaved.
- **Reset mid-packet.** All state clears immediately and any partial packet is dropped. The router must be reset in the same event.
- **FIFO wrap-around.** Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-cycle with `in_valid`=1 -> all outputs are at reset values immediately, `credit_count`=2, and `send_out` stays 0 while reset is held.
- **Credit starvation.** NUM_CREDITS=2, no `credit_in`, push 4-flit packet dest=5 -> exactly 2 `send_out` pulses on consecutive cycles, `credit_count`=0, remaining 2 flits held. Then pulse `credit_in` once -> exactly one more send, `is_tail_out`=0.
- **Dest latching.** Push 3-flit packet with `in_dest`=3 on the head and `in_dest`=9 on the body flits -> all three sent flits carry `dest_out`=3. Only the third has `is_tail_out`=1.
- **Simultaneous inject and credit.** At count=1, inject and `credit_in` in the same cycle -> `credit_count` stays 1, no overflow.
- **Overflow.** At count=2 and idle, pulse `credit_in` -> `credit_overflow`=1, count stays 2, and the flag persists until reset.
- **Full FIFO.** FIFO_DEPTH=4, credits 0, push 6 flits -> `in_ready` deasserts after the 4th accept. Return credits -> 4 sends in order, `in_ready` reasserts, and the final flits follow without loss or reorder.
